change_trace_fifo: RTL and testbench

- Synthesisable monitor-side counterpart to a signal driver: watches a W-bit vector and emits one timestamped event each time the value changes.
- Events are queued in a small FIFO and drained by a consumer over a valid/ready handshake.
- Provides a hardware equivalent of value-change printing, sitting beside the logic under observation.

---
 rtl/change_trace_fifo_pkg.sv | 19 +
 rtl/change_trace_fifo_sync_fifo.sv | 65 ++++++
 rtl/change_trace_fifo.sv | 81 ++++++++
 tb/tb_change_trace_fifo.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/change_trace_fifo_pkg.sv
// change_trace_pkg: shared event type, default sizes and the count-width helper
// for the change trace monitor. Optional build macro: CHANGE_TRACE_COALESCE_EN.
package change_trace_pkg;

    localparam int EV_W     = 3;
    localparam int EV_DEPTH = 4;
    localparam int EV_TS_W  = 8;

    typedef struct packed {
        logic [EV_W-1:0]    data;
        logic [EV_TS_W-1:0] ts;
    } ev_t;

    // Occupancy counter width: must be able to hold the value DEPTH itself.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/change_trace_fifo_sync_fifo.sv
// sync_fifo: DEPTH x DW storage with push/pop, full/empty and occupancy.
// Pop is ignored when empty; push is accepted when not full or when a pop
// frees a slot in the same cycle. With CHANGE_TRACE_COALESCE_EN defined an
// extra overwrite port replaces the tail entry on a push that cannot land.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
`ifdef CHANGE_TRACE_COALESCE_EN
    input  logic                   overwrite,
`endif
    input  logic [DW-1:0]          din,
    output logic [DW-1:0]          dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rptr];

    // Pointer/count update and storage write; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
`ifdef CHANGE_TRACE_COALESCE_EN
            else if (overwrite && full && !do_pop) begin
                // Newest entry sits just behind the write pointer.
                mem[wptr - 1'b1] <= din;
            end
`endif
            if (do_pop)
                rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/change_trace_fifo.sv
// change_trace_fifo: watches sample_i and queues a timestamped event each time
// it changes (the first edge after reset always records). Events drain over a
// valid/ready handshake. overflow_o is sticky once an event is lost.
// Optional build macro: CHANGE_TRACE_COALESCE_EN -- when full, the newest
// queued event is overwritten instead of dropping the new one.
module change_trace_fifo
    import change_trace_pkg::*;
#(
    parameter int W     = EV_W,
    parameter int DEPTH = EV_DEPTH,
    parameter int TS_W  = EV_TS_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [W-1:0]              sample_i,
    output logic                      ev_valid_o,
    input  logic                      ev_ready_i,
    output logic [W-1:0]              ev_data_o,
    output logic [TS_W-1:0]           ev_ts_o,
    output logic [cnt_w(DEPTH)-1:0]   count_o,
    output logic                      overflow_o
);

    localparam int EW = W + TS_W;

    logic [TS_W-1:0] ts_q;
    logic [W-1:0]    prev_q;
    logic            primed_q;
    logic            ovf_q;
    logic            change;
    logic            pop;
    logic            full;
    logic            empty;
    logic [EW-1:0]   fifo_din;
    logic [EW-1:0]   fifo_dout;

    assign change   = !primed_q || (sample_i != prev_q);
    assign pop      = ev_valid_o && ev_ready_i;
    // Event carries the counter value before this edge's increment.
    assign fifo_din = {sample_i, ts_q};

    // Timestamp, previous-sample, primed flag and sticky overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            prev_q   <= '0;
            primed_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            ts_q     <= ts_q + 1'b1;
            prev_q   <= sample_i;
            primed_q <= 1'b1;
            if (change && full && !pop)
                ovf_q <= 1'b1;
        end
    end

    sync_fifo #(
        .DEPTH (DEPTH),
        .DW    (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (change),
        .pop       (pop),
`ifdef CHANGE_TRACE_COALESCE_EN
        .overwrite (change),
`endif
        .din       (fifo_din),
        .dout      (fifo_dout),
        .full      (full),
        .empty     (empty),
        .count     (count_o)
    );

    assign ev_valid_o = !empty;
    assign ev_data_o  = fifo_dout[EW-1:TS_W];
    assign ev_ts_o    = fifo_dout[TS_W-1:0];
    assign overflow_o = ovf_q;

endmodule

// File: tb/tb_change_trace_fifo.sv
// tb_change_trace_fifo: scoreboard bench for change_trace_fifo. A reference
// model queue is updated at each edge; head/count/overflow are compared each
// cycle, and accepted events are checked against hand-derived lists.
// Honours CHANGE_TRACE_COALESCE_EN for the full-FIFO expectations.
module tb_change_trace_fifo;
    import change_trace_pkg::*;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [EV_W-1:0]  sample_i = '0;
    logic             ev_ready_i = 1'b0;
    logic             ev_valid_o;
    logic [EV_W-1:0]  ev_data_o;
    logic [EV_TS_W-1:0] ev_ts_o;
    logic [cnt_w(EV_DEPTH)-1:0] count_o;
    logic             overflow_o;

    int n_chk = 0;
    int n_err = 0;
    int vcyc  = 0;

    ev_t m_q[$];
    ev_t dut_log[$];
    logic [EV_TS_W-1:0] m_ts;
    logic [EV_W-1:0]    m_prev;
    logic               m_primed;
    logic               m_ovf;

    change_trace_fifo dut (
        .clk        (clk),
        .rst        (rst),
        .sample_i   (sample_i),
        .ev_valid_o (ev_valid_o),
        .ev_ready_i (ev_ready_i),
        .ev_data_o  (ev_data_o),
        .ev_ts_o    (ev_ts_o),
        .count_o    (count_o),
        .overflow_o (overflow_o)
    );

    always #5 clk = ~clk;

    // Reference model of the monitor, advanced on every rising edge.
    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_ts = '0; m_prev = '0; m_primed = 1'b0; m_ovf = 1'b0;
        end else begin
            bit pop, ev, full;
            pop  = (m_q.size() != 0) && ev_ready_i;
            ev   = !m_primed || (sample_i != m_prev);
            full = (m_q.size() == EV_DEPTH);
            if (pop) void'(m_q.pop_front());
            if (ev) begin
                if (full && !pop) begin
                    m_ovf = 1'b1;
`ifdef CHANGE_TRACE_COALESCE_EN
                    m_q[m_q.size()-1] = '{data: sample_i, ts: m_ts};
`endif
                end else begin
                    m_q.push_back('{data: sample_i, ts: m_ts});
                end
            end
            m_prev = sample_i; m_primed = 1'b1; m_ts = m_ts + 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one edge, log any handshake, then compare against the model.
    task automatic step(input logic [EV_W-1:0] s, input logic rdy, input logic r);
        sample_i = s; ev_ready_i = rdy; rst = r;
        if (!r && ev_valid_o && rdy)
            dut_log.push_back('{data: ev_data_o, ts: ev_ts_o});
        @(posedge clk); #1;
        chk("valid", 32'(ev_valid_o), 32'(m_q.size() != 0));
        chk("count", 32'(count_o), 32'(m_q.size()));
        chk("overflow", 32'(overflow_o), 32'(m_ovf));
        if (ev_valid_o && m_q.size() != 0) begin
            chk("head_data", 32'(ev_data_o), 32'(m_q[0].data));
            chk("head_ts", 32'(ev_ts_o), 32'(m_q[0].ts));
        end
        if (ev_valid_o) vcyc++;
    endtask

    task automatic do_reset(input logic [EV_W-1:0] s);
        step(s, 1'b0, 1'b1);
        dut_log.delete();
        vcyc = 0;
    endtask

    task automatic exp_ev(input string tag, input int idx, input logic [EV_W-1:0] d,
                          input logic [EV_TS_W-1:0] t);
        if (idx < dut_log.size()) begin
            chk({tag, "_data"}, 32'(dut_log[idx].data), 32'(d));
            chk({tag, "_ts"}, 32'(dut_log[idx].ts), 32'(t));
        end else begin
            chk({tag, "_missing"}, 32'(dut_log.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        // Reset state
        do_reset(3'b000);
        chk("rst_valid", 32'(ev_valid_o), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_ovf", 32'(overflow_o), 32'd0);

        // Constant input: exactly one event, valid for one cycle
        for (int i = 0; i < 10; i++) step(3'b000, 1'b1, 1'b0);
        chk("s1_n", 32'(dut_log.size()), 32'd1);
        exp_ev("s1_e0", 0, 3'b000, 8'd0);
        chk("s1_vcyc", 32'(vcyc), 32'd1);

        // One change before edge 3
        do_reset(3'b000);
        for (int i = 0; i < 3; i++) step(3'b000, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) step(3'b111, 1'b1, 1'b0);
        chk("s2_n", 32'(dut_log.size()), 32'd2);
        exp_ev("s2_e0", 0, 3'b000, 8'd0);
        exp_ev("s2_e1", 1, 3'b111, 8'd3);

        // Overflow with ready low, then drain
        do_reset(3'b000);
        for (int i = 0; i < 6; i++) step((i % 2) ? 3'b101 : 3'b000, 1'b0, 1'b0);
        chk("s3_count", 32'(count_o), 32'd4);
        chk("s3_ovf", 32'(overflow_o), 32'd1);
        for (int i = 0; i < 5; i++) step(3'b101, 1'b1, 1'b0);
        chk("s3_n", 32'(dut_log.size()), 32'd4);
        exp_ev("s3_e0", 0, 3'b000, 8'd0);
        exp_ev("s3_e1", 1, 3'b101, 8'd1);
        exp_ev("s3_e2", 2, 3'b000, 8'd2);
`ifdef CHANGE_TRACE_COALESCE_EN
        exp_ev("s3_e3", 3, 3'b101, 8'd5);
`else
        exp_ev("s3_e3", 3, 3'b101, 8'd3);
`endif
        chk("s3_ovf_sticky", 32'(overflow_o), 32'd1);

        // Full FIFO with simultaneous pop and push
        do_reset(3'b000);
        for (int i = 0; i < 4; i++) step(3'(i), 1'b0, 1'b0);
        chk("s4_full", 32'(count_o), 32'd4);
        step(3'b100, 1'b1, 1'b0);
        chk("s4_count", 32'(count_o), 32'd4);
        chk("s4_ovf", 32'(overflow_o), 32'd0);
        chk("s4_head", 32'(ev_data_o), 32'd1);
        for (int i = 0; i < 5; i++) step(3'b100, 1'b1, 1'b0);
        exp_ev("s4_e0", 0, 3'b000, 8'd0);
        exp_ev("s4_e4", 4, 3'b100, 8'd4);

        // Reset mid-operation
        do_reset(3'b000);
        for (int i = 0; i < 3; i++) step(3'(i), 1'b0, 1'b0);
        chk("s5_pre", 32'(count_o), 32'd3);
        do_reset(3'b110);
        chk("s5_valid", 32'(ev_valid_o), 32'd0);
        chk("s5_count", 32'(count_o), 32'd0);
        chk("s5_ovf", 32'(overflow_o), 32'd0);
        step(3'b110, 1'b0, 1'b0);
        chk("s5_data", 32'(ev_data_o), 32'd6);
        chk("s5_ts", 32'(ev_ts_o), 32'd0);

        // Timestamp wrap: change before edge 256, then before edge 257
        do_reset(3'b000);
        for (int i = 0; i < 256; i++) step(3'b000, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        exp_ev("s6_wrap0", 1, 3'b001, 8'd0);
        do_reset(3'b000);
        for (int i = 0; i < 257; i++) step(3'b000, 1'b1, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        step(3'b010, 1'b1, 1'b0);
        exp_ev("s6_wrap1", 1, 3'b010, 8'd1);

        // Random traffic against the model
        do_reset(3'b000);
        begin
            logic [EV_W-1:0] s;
            s = '0;
            for (int i = 0; i < 300; i++) begin
                if ($urandom_range(2) == 0) s = EV_W'($urandom_range(7));
                step(s, 1'($urandom_range(1)), 1'b0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
